i2c_cmd_sequencer: RTL and testbench

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

---
 rtl/i2c_seq_pkg.sv | 26 ++
 rtl/i2c_cmd_fifo.sv | 67 ++++++
 rtl/i2c_cmd_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM encoding, command field widths
// and the packed FIFO entry layout.
package i2c_seq_pkg;

  localparam int unsigned DEV_W   = 7;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = DEV_W + ADDR_W + DATA_W;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  // One queued write: {dev, addr, data}, dev in the MSBs.
  typedef struct packed {
    logic [DEV_W-1:0]  dev;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous show-ahead command FIFO with registered full/empty flags.
module i2c_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // Push is refused when full even if a pop happens in the same cycle.
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C write commands and issues them one at a time to an I2C write master.
// Optional WAIT_DONE watchdog and sticky o_timeout enabled by I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DEV_W-1:0]  i_cmd_dev,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic              i_done_flag,
  output logic              o_i2c_en,
  output logic [DEV_W-1:0]  o_device_addr,
  output logic [ADDR_W-1:0] o_data_addr,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_done_cnt
`ifdef I2C_SEQ_TIMEOUT_EN
  ,
  output logic              o_timeout
`endif
);

  state_t r_state;
  state_t w_state_nxt;

  cmd_t w_push_cmd;
  cmd_t w_head_cmd;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_push;
  logic w_pop;

  logic              r_i2c_en;
  logic              w_i2c_en_nxt;
  logic [DEV_W-1:0]  r_dev;
  logic [DEV_W-1:0]  w_dev_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [CNT_W-1:0]  r_done_cnt;
  logic [CNT_W-1:0]  w_done_cnt_nxt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_gap_cnt_nxt;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_nxt;
  logic            r_timeout;
  logic            w_timeout_nxt;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign w_push_cmd = '{dev: i_cmd_dev, addr: i_cmd_addr, data: i_cmd_data};
  assign w_push     = i_cmd_valid && !w_fifo_full;

  i2c_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_cmd),
    .i_pop   (w_pop),
    .o_dout  (w_head_cmd),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_i2c_en_nxt   = r_i2c_en;
    w_dev_nxt      = r_dev;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_done_cnt_nxt = r_done_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
`ifdef I2C_SEQ_TIMEOUT_EN
    w_to_cnt_nxt   = r_to_cnt;
    w_timeout_nxt  = r_timeout;
`endif

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_dev_nxt   = w_head_cmd.dev;
          w_addr_nxt  = w_head_cmd.addr;
          w_data_nxt  = w_head_cmd.data;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_i2c_en_nxt = 1'b1;
        w_state_nxt  = ST_WAIT_DONE;
`ifdef I2C_SEQ_TIMEOUT_EN
        w_to_cnt_nxt = '0;
`endif
      end
      ST_WAIT_DONE: begin
        if (i_done_flag) begin
          w_i2c_en_nxt   = 1'b0;
          w_done_cnt_nxt = r_done_cnt + CNT_W'(1);
          w_gap_cnt_nxt  = '0;
          w_state_nxt    = ST_GAP;
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        // Abandon the transfer without counting it as completed.
        else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_i2c_en_nxt  = 1'b0;
          w_timeout_nxt = 1'b1;
          w_gap_cnt_nxt = '0;
          w_state_nxt   = ST_GAP;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A pop from IDLE always moves to LOAD, so busy follows next state or pending entries.
    w_busy_nxt = (w_state_nxt != ST_IDLE) || !w_fifo_empty || w_push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_i2c_en   <= 1'b0;
      r_dev      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done_cnt <= '0;
      r_gap_cnt  <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_i2c_en   <= w_i2c_en_nxt;
      r_dev      <= w_dev_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done_cnt <= w_done_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
`ifdef I2C_SEQ_TIMEOUT_EN
      r_to_cnt   <= w_to_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
`endif
    end
  end

  assign o_cmd_ready   = !w_fifo_full;
  assign o_i2c_en      = r_i2c_en;
  assign o_device_addr = r_dev;
  assign o_data_addr   = r_addr;
  assign o_write_data  = r_data;
  assign o_busy        = r_busy;
  assign o_done_cnt    = r_done_cnt;
`ifdef I2C_SEQ_TIMEOUT_EN
  assign o_timeout     = r_timeout;
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed scoreboard bench for i2c_cmd_sequencer (FIFO_DEPTH=4, GAP_CYCLES=4, TIMEOUT_CYCLES=50).
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [6:0] i_cmd_dev = '0;
  logic [7:0] i_cmd_addr = '0;
  logic [7:0] i_cmd_data = '0;
  logic       i_done_flag = 1'b0;
  logic       o_i2c_en;
  logic [6:0] o_device_addr;
  logic [7:0] o_data_addr;
  logic [7:0] o_write_data;
  logic       o_busy;
  logic [7:0] o_done_cnt;
`ifdef I2C_SEQ_TIMEOUT_EN
  logic       o_timeout;
`endif

  always #10 clk = ~clk;

  i2c_cmd_sequencer #(
    .FIFO_DEPTH     (4),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_dev     (i_cmd_dev),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_data    (i_cmd_data),
    .i_done_flag   (i_done_flag),
    .o_i2c_en      (o_i2c_en),
    .o_device_addr (o_device_addr),
    .o_data_addr   (o_data_addr),
    .o_write_data  (o_write_data),
    .o_busy        (o_busy),
    .o_done_cnt    (o_done_cnt)
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    .o_timeout     (o_timeout)
`endif
  );

  int          total = 0;
  int          bad = 0;
  logic [22:0] exp_q[$];

  // Enable-edge monitor: counts rising edges and the shortest low run between issues.
  int   rise_cnt = 0;
  int   low_run = 0;
  int   min_low = 999;
  bit   have_prev = 1'b0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (o_i2c_en === 1'b1 && prev_en !== 1'b1) begin
      rise_cnt++;
      if (have_prev && low_run < min_low) min_low = low_run;
      have_prev = 1'b1;
      low_run = 0;
    end else if (o_i2c_en !== 1'b1) begin
      low_run++;
    end
    prev_en = o_i2c_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [6:0] d, input logic [7:0] a, input logic [7:0] w);
    logic acc;
    acc = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_dev   = d;
    i_cmd_addr  = a;
    i_cmd_data  = w;
    for (int k = 0; k < 200; k++) begin
      acc = o_cmd_ready;
      tick();
      if (acc) begin
        exp_q.push_back({d, a, w});
        break;
      end
    end
    i_cmd_valid = 1'b0;
    if (!acc) chk("push_accept", 32'(o_cmd_ready), 32'd1);
  endtask

  task automatic check_issue();
    logic [22:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("issue_fields", {9'd0, o_device_addr, o_data_addr, o_write_data}, {9'd0, e});
  endtask

  task automatic wait_en(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (o_i2c_en === 1'b1) break;
      tick();
    end
    chk("en_rise", 32'(o_i2c_en), 32'd1);
    check_issue();
  endtask

  task automatic pulse_done();
    i_done_flag = 1'b1;
    tick();
    i_done_flag = 1'b0;
    chk("en_low_after_done", 32'(o_i2c_en), 32'd0);
  endtask

  task automatic serve(input int dly);
    wait_en(300);
    repeat (dly) tick();
    pulse_done();
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (o_busy === 1'b0) break;
      tick();
    end
    chk("busy_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int r0;
    int hi;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_en", 32'(o_i2c_en), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done_cnt", 32'(o_done_cnt), 32'd0);
    chk("rst_fields", {9'd0, o_device_addr, o_data_addr, o_write_data}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(o_cmd_ready), 32'd1);

    // Single command: enable two cycles after push, held through a long wait
    push_cmd(7'h50, 8'h10, 8'hA5);
    tick();
    chk("en_load_cycle", 32'(o_i2c_en), 32'd0);
    chk("busy_active", 32'(o_busy), 32'd1);
    tick();
    chk("en_two_after_push", 32'(o_i2c_en), 32'd1);
    check_issue();
    repeat (100) tick();
    chk("en_held", 32'(o_i2c_en), 32'd1);
    chk("fields_stable", {9'd0, o_device_addr, o_data_addr, o_write_data}, 32'h0050_10A5);
    pulse_done();
    chk("done_cnt_1", 32'(o_done_cnt), 32'd1);
    chk("fields_hold_gap", {9'd0, o_device_addr, o_data_addr, o_write_data}, 32'h0050_10A5);
    wait_idle(50);

    // Spurious done while idle
    r0 = rise_cnt;
    i_done_flag = 1'b1;
    tick();
    i_done_flag = 1'b0;
    repeat (5) tick();
    chk("spur_done_cnt", 32'(o_done_cnt), 32'd1);
    chk("spur_busy", 32'(o_busy), 32'd0);
    chk("spur_no_txn", 32'(rise_cnt - r0), 32'd0);

    // Back-to-back commands: minimum low gap between enables
    min_low = 999;
    have_prev = 1'b0;
    push_cmd(7'h11, 8'h21, 8'h31);
    push_cmd(7'h12, 8'h22, 8'h32);
    push_cmd(7'h13, 8'h23, 8'h33);
    for (int n = 0; n < 3; n++) serve(3);
    wait_idle(50);
    chk("gap_low_cycles", 32'(min_low), 32'd6);
    chk("done_cnt_4", 32'(o_done_cnt), 32'd4);

    // FIFO full: fifth command held until a pop frees space
    push_cmd(7'h7F, 8'hFF, 8'h00);
    wait_en(20);
    push_cmd(7'h01, 8'hA1, 8'hB1);
    push_cmd(7'h02, 8'hA2, 8'hB2);
    push_cmd(7'h03, 8'hA3, 8'hB3);
    push_cmd(7'h04, 8'hA4, 8'hB4);
    chk("full_ready_low", 32'(o_cmd_ready), 32'd0);
    repeat (3) tick();
    chk("full_ready_still_low", 32'(o_cmd_ready), 32'd0);
    pulse_done();
    push_cmd(7'h05, 8'hA5, 8'hB5);
    for (int n = 0; n < 5; n++) serve(2);
    wait_idle(50);
    chk("done_cnt_10", 32'(o_done_cnt), 32'd10);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset during WAIT_DONE with two commands queued
    push_cmd(7'h60, 8'h61, 8'h62);
    wait_en(20);
    push_cmd(7'h63, 8'h64, 8'h65);
    push_cmd(7'h66, 8'h67, 8'h68);
    rst = 1'b1;
    tick();
    chk("midrst_en", 32'(o_i2c_en), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done_cnt", 32'(o_done_cnt), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    r0 = rise_cnt;
    repeat (30) tick();
    chk("midrst_no_txn", 32'(rise_cnt - r0), 32'd0);
    chk("midrst_busy_after", 32'(o_busy), 32'd0);
    chk("midrst_ready", 32'(o_cmd_ready), 32'd1);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Watchdog: done never arrives
    push_cmd(7'h22, 8'h01, 8'h02);
    wait_en(20);
    hi = 0;
    for (int k = 0; k < 200; k++) begin
      if (o_i2c_en !== 1'b1) break;
      tick();
      hi++;
    end
    chk("to_en_high_cycles", 32'(hi), 32'd50);
    chk("to_flag", 32'(o_timeout), 32'd1);
    chk("to_done_cnt", 32'(o_done_cnt), 32'd0);
    push_cmd(7'h23, 8'h03, 8'h04);
    serve(4);
    chk("to_next_done_cnt", 32'(o_done_cnt), 32'd1);
    chk("to_sticky", 32'(o_timeout), 32'd1);
    wait_idle(50);
`else
    hi = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
